mem_port_arbiter: RTL

Shares one single-port synchronous 32-bit memory (6-bit word address, 4-bit byte enable, one-cycle read latency) between the processor's instruction-fetch port and its data port. Data accesses have priority; a starvation counter guarantees fetch progress. Performs data-port byte-lane alignment for stores and extraction plus sign/zero extension for loads. Sits between the processor core and a unified memory in the top-level, replacing the split instruction/data memories.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_lane_align.sv | 66 ++++++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: access size codes, port owner
// encoding and the default fetch starvation limit.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_D    = 2'b10
    } owner_e;

    localparam int unsigned DEFAULT_STARVE_LIMIT = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the unified memory port.
// The arbiter uses the slave view; the core plus memory use the master view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [5:0]  mem_address;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  mem_q,
        output if_gnt, if_rvalid, if_rdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_byteena, mem_data, mem_wren
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output mem_q,
        input  if_gnt, if_rvalid, if_rdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_byteena, mem_data, mem_wren
    );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic for the data port: store lane placement,
// misalignment detection and load extraction with sign/zero extension.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic        o_misaligned,
    output logic [3:0]  o_st_byteena,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_offset,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_mem_q,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;
    logic        w_sign_b;
    logic        w_sign_h;

    always_comb begin
        o_misaligned = 1'b0;
        case (size_e'(i_size))
            SZ_BYTE: o_misaligned = 1'b0;
            SZ_HALF: o_misaligned = i_offset[0];
            SZ_WORD: o_misaligned = (i_offset != 2'b00);
            default: o_misaligned = 1'b1;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign o_st_byteena[gi] = (size_e'(i_size) == SZ_WORD)
                                   || (size_e'(i_size) == SZ_HALF && i_offset[1] == LANE[1])
                                   || (size_e'(i_size) == SZ_BYTE && i_offset == LANE);
        end
    endgenerate

    // Store data is replicated across lanes; byteena picks the live copy.
    always_comb begin
        o_st_data = i_wdata;
        case (size_e'(i_size))
            SZ_BYTE: o_st_data = {4{i_wdata[7:0]}};
            SZ_HALF: o_st_data = {2{i_wdata[15:0]}};
            default: o_st_data = i_wdata;
        endcase
    end

    assign w_shifted = i_mem_q >> {i_ld_offset, 3'b000};
    assign w_sign_b  = ~i_ld_unsigned & w_shifted[7];
    assign w_sign_h  = ~i_ld_unsigned & w_shifted[15];

    always_comb begin
        o_ld_data = w_shifted;
        case (size_e'(i_ld_size))
            SZ_BYTE: o_ld_data = {{24{w_sign_b}}, w_shifted[7:0]};
            SZ_HALF: o_ld_data = {{16{w_sign_h}}, w_shifted[15:0]};
            default: o_ld_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port synchronous memory.
// Data has priority; a saturating starvation counter lets fetch win eventually.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT
)
(
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  r_starve_cnt;
    owner_e      r_owner;
    logic [1:0]  r_ld_size;
    logic [1:0]  r_ld_offset;
    logic        r_ld_unsigned;
    logic        r_err;

    logic        w_misaligned;
    logic [3:0]  w_st_byteena;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;
    logic        w_d_valid;
    logic        w_starved;
    logic        w_if_gnt;
    logic        w_d_gnt;
    logic        w_d_access;
    logic        w_if_rvalid;
    logic        w_d_rvalid;

    mem_lane_align u_align (
        .i_size        (bus.d_size),
        .i_offset      (bus.d_addr[1:0]),
        .i_wdata       (bus.d_wdata),
        .o_misaligned  (w_misaligned),
        .o_st_byteena  (w_st_byteena),
        .o_st_data     (w_st_data),
        .i_ld_size     (r_ld_size),
        .i_ld_offset   (r_ld_offset),
        .i_ld_unsigned (r_ld_unsigned),
        .i_mem_q       (bus.mem_q),
        .o_ld_data     (w_ld_data)
    );

    // An erroring data request is acknowledged without touching memory,
    // so it never blocks a simultaneous fetch.
    assign w_d_valid  = bus.d_req && !w_misaligned;
    assign w_starved  = (r_starve_cnt >= LIMIT);
    assign w_if_gnt   = reset && bus.if_req && (!w_d_valid || w_starved);
    assign w_d_gnt    = reset && bus.d_req && (w_misaligned || !(bus.if_req && w_starved));
    assign w_d_access = w_d_gnt && !w_misaligned;

    always_comb begin
        bus.mem_address = '0;
        bus.mem_byteena = '0;
        bus.mem_data    = '0;
        bus.mem_wren    = 1'b0;
        if (w_if_gnt) begin
            bus.mem_address = bus.if_addr[7:2];
            bus.mem_byteena = 4'b1111;
        end else if (w_d_access) begin
            bus.mem_address = bus.d_addr[7:2];
            bus.mem_wren    = bus.d_we;
            bus.mem_byteena = bus.d_we ? w_st_byteena : 4'b1111;
            bus.mem_data    = bus.d_we ? w_st_data : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt  <= '0;
            r_owner       <= OWN_NONE;
            r_ld_size     <= '0;
            r_ld_offset   <= '0;
            r_ld_unsigned <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            if (bus.if_req && !w_if_gnt)
                r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
            else
                r_starve_cnt <= '0;

            r_err <= w_d_gnt && w_misaligned;

            if (w_if_gnt)
                r_owner <= OWN_IF;
            else if (w_d_access && !bus.d_we)
                r_owner <= OWN_D;
            else
                r_owner <= OWN_NONE;

            if (w_d_access) begin
                r_ld_size     <= bus.d_size;
                r_ld_offset   <= bus.d_addr[1:0];
                r_ld_unsigned <= bus.d_unsigned;
            end
        end
    end

    assign w_if_rvalid   = (r_owner == OWN_IF);
    assign w_d_rvalid    = (r_owner == OWN_D);

    assign bus.if_gnt    = w_if_gnt;
    assign bus.d_gnt     = w_d_gnt;
    assign bus.if_rvalid = w_if_rvalid;
    assign bus.d_rvalid  = w_d_rvalid;
    assign bus.if_rdata  = w_if_rvalid ? bus.mem_q : 32'd0;
    assign bus.d_rdata   = w_d_rvalid ? w_ld_data : 32'd0;
    assign bus.d_err     = r_err;

endmodule
